sdm_dac_mod2: RTL

- Parametrised successor to the first-order PDM sigma-delta DAC modulator. Width is generic, and loop order (1 or 2) is selectable at run time.
- Takes signed PCM samples through a valid/ready handshake paced by an oversampling counter. Integrators saturate, overload is reported, and mute is supported.
- Sits between the sample source and the 1-bit output pin/RC filter, clocked by the 25 MHz PLL output.

---
 rtl/sdm_dac_mod2.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sdm_dac_mod2.sv
// -----------------------------------------------------------------------------
// sdm_dac_mod2
//   Sigma-delta PDM DAC modulator with run-time selectable loop order (1 or 2).
//   Signed PCM samples are accepted once every OSR clocks through a
//   valid/ready handshake. Integrators saturate, overload is reported as a
//   sticky flag, and the modulator input can be muted.
//
// Parameters
//   N    input sample width, signed two's complement; full scale FS = 2^(N-1)
//   OSR  clk_25 cycles per accepted input sample (>= 2)
//
// Ports
//   clk_25     in   modulator clock (25 MHz PLL output)
//   areset     in   asynchronous active-low reset
//   din        in   signed input sample [N-1:0]
//   din_valid  in   din holds a valid sample
//   din_ready  out  block accepts a sample this cycle
//   order_sel  in   0 = first-order loop, 1 = second-order loop
//   mute       in   forces modulator input to 0 while high
//   ovl_clr    in   clears the sticky overload flag
//   pdm        out  registered 1-bit PDM output (1 represents +FS)
//   overload   out  sticky: an integrator saturated
//   underrun   out  one-cycle pulse: no sample was offered in a ready cycle
//
// Handshake: a sample transfers on a rising clk_25 edge where din_valid and
// din_ready are both high. din_ready is high for exactly one cycle in every
// OSR, and does not depend on din_valid. din_valid in other cycles is ignored.
// -----------------------------------------------------------------------------
module sdm_dac_mod2 #(
    parameter int N   = 16,
    parameter int OSR = 64
) (
    input  logic         clk_25,
    input  logic         areset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         order_sel,
    input  logic         mute,
    input  logic         ovl_clr,
    output logic         pdm,
    output logic         overload,
    output logic         underrun
);

    localparam int W  = N + 4;          // integrator width
    localparam int S  = N + 5;          // width of intermediate sums
    localparam int CW = $clog2(OSR);

    localparam logic [CW-1:0]       CNT_LAST = CW'(OSR - 1);
    localparam logic signed [S-1:0] FS_S     = S'(2 ** (N - 1));
    localparam logic signed [S-1:0] SAT_HI   = S'(2 ** (N + 2));
    localparam logic signed [S-1:0] SAT_MAX  = SAT_HI - S'(1);
    localparam logic signed [S-1:0] SAT_MIN  = -SAT_HI;

    logic [CW-1:0]       r_osr_cnt;
    logic [N-1:0]        r_sample;
    logic signed [W-1:0] r_acc1;
    logic signed [W-1:0] r_acc2;
    logic                r_order_q;
    logic                r_pdm;
    logic                r_overload;
    logic                r_underrun;

    logic signed [S-1:0] w_x;
    logic signed [S-1:0] w_fb;
    logic signed [S-1:0] w_sum1;
    logic signed [S-1:0] w_sum2;
    logic signed [W-1:0] w_a1;
    logic signed [W-1:0] w_a2;
    logic                w_clamp1;
    logic                w_clamp2;
    logic                w_clamp;
    logic                w_order_chg;

    // Ready is decoded from the counter register so it never depends on inputs.
    assign din_ready = (r_osr_cnt == CNT_LAST);

    // Mute acts on the loop input directly; the sample register keeps loading.
    assign w_x  = mute ? '0 : {{(S - N){r_sample[N-1]}}, r_sample};
    assign w_fb = r_pdm ? FS_S : -FS_S;

    assign w_sum1 = {{(S - W){r_acc1[W-1]}}, r_acc1} + w_x - w_fb;
    // The second stage integrates the already-saturated first-stage value.
    assign w_sum2 = {{(S - W){r_acc2[W-1]}}, r_acc2}
                  + {{(S - W){w_a1[W-1]}}, w_a1} - w_fb;

    always_comb begin
        w_clamp1 = 1'b0;
        w_a1     = w_sum1[W-1:0];
        if (w_sum1 > SAT_MAX) begin
            w_clamp1 = 1'b1;
            w_a1     = SAT_MAX[W-1:0];
        end else if (w_sum1 < SAT_MIN) begin
            w_clamp1 = 1'b1;
            w_a1     = SAT_MIN[W-1:0];
        end
    end

    always_comb begin
        w_clamp2 = 1'b0;
        w_a2     = w_sum2[W-1:0];
        if (w_sum2 > SAT_MAX) begin
            w_clamp2 = 1'b1;
            w_a2     = SAT_MAX[W-1:0];
        end else if (w_sum2 < SAT_MIN) begin
            w_clamp2 = 1'b1;
            w_a2     = SAT_MIN[W-1:0];
        end
    end

    // The second stage only counts towards overload when it is in the loop.
    assign w_clamp     = w_clamp1 | (r_order_q & w_clamp2);
    assign w_order_chg = (order_sel != r_order_q);

    always_ff @(posedge clk_25 or negedge areset) begin
        if (!areset) begin
            r_osr_cnt  <= '0;
            r_sample   <= '0;
            r_acc1     <= '0;
            r_acc2     <= '0;
            r_order_q  <= 1'b0;
            r_pdm      <= 1'b0;
            r_overload <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_osr_cnt  <= din_ready ? '0 : r_osr_cnt + CW'(1);
            r_underrun <= din_ready & ~din_valid;
            if (din_ready && din_valid) begin
                r_sample <= din;
            end

            if (w_order_chg) begin
                // Restart the loop cleanly in the new order; skip this update.
                r_order_q <= order_sel;
                r_acc1    <= '0;
                r_acc2    <= '0;
                r_pdm     <= 1'b0;
                if (ovl_clr) begin
                    r_overload <= 1'b0;
                end
            end else begin
                r_acc1 <= w_a1;
                if (r_order_q) begin
                    r_acc2 <= w_a2;
                    r_pdm  <= ~w_a2[W-1];
                end else begin
                    r_acc2 <= '0;
                    r_pdm  <= ~w_a1[W-1];
                end
                // A clamp in the same cycle as a clear leaves the flag set.
                if (w_clamp) begin
                    r_overload <= 1'b1;
                end else if (ovl_clr) begin
                    r_overload <= 1'b0;
                end
            end
        end
    end

    assign pdm      = r_pdm;
    assign overload = r_overload;
    assign underrun = r_underrun;

endmodule
